// File: rtl/fifo_rd_drain_vld_rdy_pkg.sv
// ----------------------------------------------------------------------------
// fifo_rd_drain_vld_rdy_pkg : shared constants and error-cause encoding | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_rd_drain_vld_rdy_pkg;

  localparam int BUF_DEPTH  = 3;
  localparam int BUF_PTR_WD = 2;

  // First protocol violation seen since reset; debug visibility only.
  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_UNEXP_VAL = 2'd1,
    ERR_MISS_VAL  = 2'd2,
    ERR_OVERFLOW  = 2'd3
  } err_cause_e;

  function automatic logic [BUF_PTR_WD-1:0] ptr_inc(input logic [BUF_PTR_WD-1:0] p);
    return (p == BUF_PTR_WD'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pfb_reg3.sv
// ----------------------------------------------------------------------------
// pfb_reg3 : 3-entry prefetch register array, one write port, comb read | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pfb_reg3
  import fifo_rd_drain_vld_rdy_pkg::*;
#(
  parameter int DATA_WD = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_val,
  input  logic [BUF_PTR_WD-1:0] wr_ptr,
  input  logic [DATA_WD-1:0]    wr_dat,
  input  logic [BUF_PTR_WD-1:0] rd_ptr,
  output logic [DATA_WD-1:0]    rd_dat
);

  logic [DATA_WD-1:0] mem_r [BUF_DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_r[i] <= '0;
    end else if (wr_val) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (wr_ptr == BUF_PTR_WD'(i)) mem_r[i] <= wr_dat;
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    case (rd_ptr)
      2'd0:    rd_dat = mem_r[0];
      2'd1:    rd_dat = mem_r[1];
      2'd2:    rd_dat = mem_r[2];
      default: rd_dat = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_drain_vld_rdy.sv
// ----------------------------------------------------------------------------
// fifo_rd_drain_vld_rdy : credit-based FIFO drain into a valid/ready stream | rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_rd_drain_vld_rdy
  import fifo_rd_drain_vld_rdy_pkg::*;
#(
  parameter  int DATA_WD = -1,
  parameter  int PKT_LEN = 4,
  localparam int BEAT_WD = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               fifo_ept_i,
  output logic               fifo_rd_o,
  input  logic               fifo_val_i,
  input  logic [DATA_WD-1:0] fifo_dat_i,
  output logic               out_val_o,
  input  logic               out_rdy_i,
  output logic [DATA_WD-1:0] out_dat_o,
  output logic               out_lst_o,
  output logic [1:0]         buf_cnt_o,
  output logic               err_o
);

  logic                  run_r;
  logic                  infl_r;
  logic [1:0]            cnt_r;
  logic [BUF_PTR_WD-1:0] wr_ptr_r;
  logic [BUF_PTR_WD-1:0] rd_ptr_r;
  logic [BEAT_WD-1:0]    beat_r;
  err_cause_e            err_cause_r;

  logic       pop;
  logic       full;
  logic       capture;
  logic       beat_last;
  logic       e_unexp;
  logic       e_miss;
  logic       e_ovf;
  logic [2:0] credit_used;

  // run_r is low for the first cycle after reset release: no issue, and a
  // straggling read response from before reset is silently dropped.
  assign credit_used = {1'b0, cnt_r} + {2'b00, infl_r};
  assign fifo_rd_o   = run_r && !fifo_ept_i && (credit_used < 3'(BUF_DEPTH));

  assign out_val_o = (cnt_r != 2'd0);
  assign pop       = out_val_o && out_rdy_i;
  assign full      = (cnt_r == 2'(BUF_DEPTH));
  assign capture   = fifo_val_i && infl_r && !(full && !pop);
  assign beat_last = (beat_r == BEAT_WD'(PKT_LEN - 1));
  assign out_lst_o = out_val_o && beat_last;
  assign buf_cnt_o = cnt_r;

  assign e_unexp = fifo_val_i && !infl_r && run_r;
  assign e_miss  = infl_r && !fifo_val_i;
  assign e_ovf   = fifo_val_i && full && !pop;
  assign err_o   = (err_cause_r != ERR_NONE);

  pfb_reg3 #(
    .DATA_WD (DATA_WD)
  ) u_pfb (
    .clk    (clk),
    .rstn   (rstn),
    .wr_val (capture),
    .wr_ptr (wr_ptr_r),
    .wr_dat (fifo_dat_i),
    .rd_ptr (rd_ptr_r),
    .rd_dat (out_dat_o)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_r       <= 1'b0;
      infl_r      <= 1'b0;
      cnt_r       <= 2'd0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      beat_r      <= '0;
      err_cause_r <= ERR_NONE;
    end else begin
      run_r  <= 1'b1;
      infl_r <= fifo_rd_o;

      if (capture) wr_ptr_r <= ptr_inc(wr_ptr_r);

      if (pop) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
        beat_r   <= beat_last ? '0 : beat_r + 1'b1;
      end

      case ({capture, pop})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase

      if (err_cause_r == ERR_NONE) begin
        if (e_unexp)     err_cause_r <= ERR_UNEXP_VAL;
        else if (e_miss) err_cause_r <= ERR_MISS_VAL;
        else if (e_ovf)  err_cause_r <= ERR_OVERFLOW;
      end
    end
  end

endmodule

`default_nettype wire
